serial_tx_word: RTL and testbench

Parameterised word serializer: accepts an n-bit word on a single-cycle load strobe and shifts it out on one serial line framed by start and stop bits. It is the transmit end of the enable-qualified capture registers in the datapath: it turns a parallel word back into a timed bit stream that a shift-in receiver can rebuild. The block is fully synchronous to one clock, and all outputs are registered.

---
 rtl/serial_tx_word.sv | 116 +++++++++++
 tb/tb_serial_tx_word.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_word.sv
// Word serializer: frames an n-bit word with start/stop bits, LSB first.
// All outputs are registered; reset aborts any frame in flight.
module serial_tx_word #(
    parameter int n          = 4,
    parameter int BIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] D,
    output logic         sout,
    output logic         ready,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int IW = $clog2(n + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CW-1:0] CLAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] ILAST = IW'(n - 1);

    logic [1:0]    state, state_n;
    logic [n-1:0]  sh, sh_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [IW-1:0] idx, idx_n;
    logic          sout_n;
    logic          done_n;
    logic          last;

    assign last = (cyc == CLAST);

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cyc_n   = cyc;
        idx_n   = idx;
        done_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (load) begin
                    sh_n    = D;
                    cyc_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (last) begin
                    cyc_n   = '0;
                    idx_n   = '0;
                    state_n = S_DATA;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            S_DATA: begin
                if (last) begin
                    sh_n  = sh >> 1;
                    cyc_n = '0;
                    if (idx == ILAST) state_n = S_STOP;
                    else              idx_n   = idx + 1'b1;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            S_STOP: begin
                if (last) begin
                    cyc_n   = '0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Line level is derived from the next state so sout stays a pure flop.
    always_comb begin
        sout_n = 1'b1;
        unique case (state_n)
            S_START: sout_n = 1'b0;
            S_DATA:  sout_n = sh_n[0];
            default: sout_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            sh    <= '0;
            cyc   <= '0;
            idx   <= '0;
            sout  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            cyc   <= cyc_n;
            idx   <= idx_n;
            sout  <= sout_n;
            ready <= (state_n == S_IDLE);
            busy  <= (state_n != S_IDLE);
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_tx_word.sv
// Bench for serial_tx_word: n=4/BIT_CYCLES=2 instance via scoreboard,
// n=1/BIT_CYCLES=1 instance via hand-written sequences.
`timescale 1ns/1ps
module tb_serial_tx_word;

    typedef struct packed {
        logic sout;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic [3:0]  d;
        logic [11:0] seq;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] d;
    logic       sout, ready, busy, done;

    logic       load_b;
    logic [0:0] db;
    logic       sout_b, ready_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    vec_t vecs[8];

    serial_tx_word #(.n(4), .BIT_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .D     (d),
        .sout  (sout),
        .ready (ready),
        .busy  (busy),
        .done  (done)
    );

    serial_tx_word #(.n(1), .BIT_CYCLES(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .load  (load_b),
        .D     (db),
        .sout  (sout_b),
        .ready (ready_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_vec(input int i);
        for (int c = 0; c < 12; c++)
            q.push_back(exp_t'{vecs[i].seq[11-c], 1'b1, 1'b0});
        q.push_back(exp_t'{1'b1, 1'b0, 1'b1});
    endtask

    // One clock: advance, sample mid-cycle, compare against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (q.size() == 0) e = exp_t'{1'b1, 1'b0, 1'b0};
        else               e = q.pop_front();
        chk("a_sout",  sout,  e.sout);
        chk("a_busy",  busy,  e.busy);
        chk("a_done",  done,  e.done);
        chk("a_ready", ready, ~e.busy);
    endtask

    task automatic send(input int i);
        load = 1'b1;
        d    = vecs[i].d;
        push_vec(i);
        for (int c = 0; c < 14; c++) begin
            step();
            if (c == 0) load = 1'b0;
        end
    endtask

    task automatic b_frame(input logic bit_in, input logic [3:0] exp_sout);
        logic [3:0] exp_rdy;
        logic [3:0] exp_done;
        int lowcnt;
        exp_rdy  = 4'b0001;
        exp_done = 4'b0001;
        lowcnt   = 0;
        load_b   = 1'b1;
        db       = bit_in;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b_sout",  sout_b,  exp_sout[3-c]);
            chk("b_ready", ready_b, exp_rdy[3-c]);
            chk("b_done",  done_b,  exp_done[3-c]);
            chk("b_busy",  busy_b,  ~exp_rdy[3-c]);
            if (!ready_b) lowcnt++;
            if (c == 0) load_b = 1'b0;
        end
        checks++;
        if (lowcnt != 3) begin
            errors++;
            $display("FAIL b_ready_low_cycles: got %0d expected 3", lowcnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'd12, 12'b000000111111};
        vecs[1] = '{4'd5,  12'b001100110011};
        vecs[2] = '{4'd0,  12'b000000000011};
        vecs[3] = '{4'd15, 12'b001111111111};
        vecs[4] = '{4'd8,  12'b000000001111};
        vecs[5] = '{4'd2,  12'b000011000011};
        vecs[6] = '{4'd9,  12'b001100001111};
        vecs[7] = '{4'd13, 12'b001100111111};

        reset  = 1'b0;
        load   = 1'b0;
        d      = '0;
        load_b = 1'b0;
        db     = '0;

        #5 reset = 1'b1;
        #1;
        chk("rst_a_sout",  sout,    1'b1);
        chk("rst_a_ready", ready,   1'b1);
        chk("rst_a_busy",  busy,    1'b0);
        chk("rst_a_done",  done,    1'b0);
        chk("rst_b_sout",  sout_b,  1'b1);
        chk("rst_b_ready", ready_b, 1'b1);
        #9 reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) send(i);

        // Load while busy must be ignored.
        load = 1'b1;
        d    = 4'd8;
        push_vec(4);
        for (int c = 0; c < 14; c++) begin
            step();
            if (c == 0) load = 1'b0;
            if (c == 3) begin load = 1'b1; d = 4'd1; end
            if (c == 4) load = 1'b0;
        end

        // Back-to-back with load held high.
        load = 1'b1;
        d    = 4'd2;
        push_vec(5);
        for (int c = 0; c < 13; c++) step();
        d = 4'd9;
        push_vec(6);
        for (int c = 0; c < 14; c++) begin
            step();
            if (c == 0) load = 1'b0;
        end

        // Reset during data bit 2 of D=13.
        load = 1'b1;
        d    = 4'd13;
        push_vec(7);
        for (int c = 0; c < 7; c++) begin
            step();
            if (c == 0) load = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        chk("midrst_sout",  sout,  1'b1);
        chk("midrst_busy",  busy,  1'b0);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_done",  done,  1'b0);
        #9 reset = 1'b0;
        q.delete();
        for (int c = 0; c < 16; c++) step();
        send(1);

        b_frame(1'b1, 4'b0111);
        b_frame(1'b0, 4'b0011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
